// File: rtl/fb_ctrl_pkg.sv
// Shared types for the Firebird pipeline control unit: FSM encoding and
// the bundle of pipeline-register enables/clears.
package fb_ctrl_pkg;

    typedef enum logic [1:0] {
        FB_ST_RUN    = 2'd0,
        FB_ST_DRAIN  = 2'd1,
        FB_ST_HALTED = 2'd2
    } fb_state_e;

    localparam int FB_DRAIN_CYCLES_DEF = 3;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_clr;
        logic idex_we;
        logic idex_clr;
        logic exmem_we;
    } fb_ctrl_t;

endpackage

// File: rtl/fb_hazard_detect.sv
// Load-use detector: a load in EX whose rd feeds a source operand of ID.
module fb_hazard_detect (
    input  logic [4:0] id_register_rs1,
    input  logic [4:0] id_register_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_register_rd,
    output logic       load_use
);

    logic hit_rs1, hit_rs2;

    assign hit_rs1  = id_uses_rs1 && (ex_register_rd == id_register_rs1);
    assign hit_rs2  = id_uses_rs2 && (ex_register_rd == id_register_rs2);
    // x0 is hardwired zero, so a load to it never creates a dependency
    assign load_use = ex_mem_read && (ex_register_rd != 5'd0) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/fb_hazard_ctrl.sv
// Firebird pipeline control: hazard priority, debug halt drain FSM and
// stall/flush performance counters.
module fb_hazard_ctrl
    import fb_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = FB_DRAIN_CYCLES_DEF,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_register_rs1,
    input  logic [4:0]       id_register_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_register_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    input  logic             halt_req,
    input  logic             cnt_clr,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_clr,
    output logic             idex_we,
    output logic             idex_clr,
    output logic             exmem_we,
    output logic             halt_ack,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int DC_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DC_W-1:0] DC_LOAD = DC_W'(DRAIN_CYCLES);

    logic            load_use;
    logic            advance;
    fb_state_e       state, state_nxt;
    logic [DC_W-1:0] dcnt, dcnt_nxt;
    fb_ctrl_t        hz, ctl;

    fb_hazard_detect u_hz (
        .id_register_rs1 (id_register_rs1),
        .id_register_rs2 (id_register_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_mem_read     (ex_mem_read),
        .ex_register_rd  (ex_register_rd),
        .load_use        (load_use)
    );

    assign advance = !mem_busy && !load_use;

    always_comb begin
        hz = '{default: 1'b1, ifid_clr: 1'b0, idex_clr: 1'b0};
        if (mem_busy) begin
            hz = '0;
        end else if (ex_branch_taken) begin
            hz = '{default: 1'b1};
        end else if (load_use) begin
            hz = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_clr: 1'b0,
                   idex_we: 1'b1, idex_clr: 1'b1, exmem_we: 1'b1};
        end
    end

    always_comb begin
        ctl       = hz;
        state_nxt = state;
        dcnt_nxt  = dcnt;
        halt_ack  = 1'b0;
        case (state)
            FB_ST_RUN: begin
                if (halt_req) begin
                    state_nxt = FB_ST_DRAIN;
                    dcnt_nxt  = DC_LOAD;
                end
            end
            FB_ST_DRAIN: begin
                if (!ex_branch_taken) ctl.pc_we = 1'b0;
                // only bubble IF/ID when ID moves on, so a stalled or frozen ID survives
                if (advance) ctl.ifid_clr = 1'b1;
                if (!halt_req) begin
                    state_nxt = FB_ST_RUN;
                    dcnt_nxt  = '0;
                end else if (ex_branch_taken && !mem_busy) begin
                    dcnt_nxt = DC_LOAD;
                end else if (advance) begin
                    if (dcnt <= DC_W'(1)) begin
                        state_nxt = FB_ST_HALTED;
                        dcnt_nxt  = '0;
                    end else begin
                        dcnt_nxt = dcnt - DC_W'(1);
                    end
                end
            end
            FB_ST_HALTED: begin
                ctl      = '0;
                halt_ack = 1'b1;
                if (!halt_req) state_nxt = FB_ST_RUN;
            end
            default: begin
                state_nxt = FB_ST_RUN;
                dcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FB_ST_RUN;
            dcnt  <= '0;
        end else begin
            state <= state_nxt;
            dcnt  <= dcnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else if (cnt_clr) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if ((mem_busy || load_use) && state != FB_ST_HALTED)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (ex_branch_taken && !mem_busy)
                flush_count <= flush_count + CNT_W'(1);
        end
    end

    assign pc_we    = ctl.pc_we;
    assign ifid_we  = ctl.ifid_we;
    assign ifid_clr = ctl.ifid_clr;
    assign idex_we  = ctl.idex_we;
    assign idex_clr = ctl.idex_clr;
    assign exmem_we = ctl.exmem_we;

endmodule

// File: tb/tb_fb_hazard_ctrl.sv
// Directed bench for fb_hazard_ctrl: hazards, freeze, halt drain, reset, counter wrap.
module tb_fb_hazard_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_register_rs1, id_register_rs2, ex_register_rd;
    logic          id_uses_rs1, id_uses_rs2, ex_mem_read;
    logic          ex_branch_taken, mem_busy, halt_req, cnt_clr;
    logic          pc_we, ifid_we, ifid_clr, idex_we, idex_clr, exmem_we, halt_ack;
    logic [CW-1:0] stall_cycles, flush_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fb_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_register_rs1 (id_register_rs1),
        .id_register_rs2 (id_register_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_mem_read     (ex_mem_read),
        .ex_register_rd  (ex_register_rd),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .halt_req        (halt_req),
        .cnt_clr         (cnt_clr),
        .pc_we           (pc_we),
        .ifid_we         (ifid_we),
        .ifid_clr        (ifid_clr),
        .idex_we         (idex_we),
        .idex_clr        (idex_clr),
        .exmem_we        (exmem_we),
        .halt_ack        (halt_ack),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_register_rs1 = 5'd0; id_register_rs2 = 5'd0; ex_register_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; mem_busy = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2);
        ex_mem_read = 1'b1; ex_register_rd = rd;
        id_register_rs1 = rs1; id_uses_rs1 = u1;
        id_register_rs2 = rs2; id_uses_rs2 = u2;
    endtask

    task automatic clr_cnt();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    initial begin
        idle();
        halt_req = 1'b0;
        rst = 1'b0;
        #3;
        chk("rst_halt_ack", halt_ack, 0);
        chk("rst_stall", stall_cycles, 0);
        chk("rst_flush", flush_count, 0);
        chk("rst_pc_we", pc_we, 1);
        chk("rst_idex_clr", idex_clr, 0);
        tick();
        rst = 1'b1;
        tick();

        // load-use on rs1
        set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        #1;
        chk("lu_pc_we", pc_we, 0);
        chk("lu_ifid_we", ifid_we, 0);
        chk("lu_idex_clr", idex_clr, 1);
        chk("lu_exmem_we", exmem_we, 1);
        tick();
        idle();
        #1;
        chk("lu_one_cycle_pc_we", pc_we, 1);
        chk("lu_stall_cnt", stall_cycles, 1);
        // rd = x0 never stalls
        set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        #1;
        chk("lu_x0_pc_we", pc_we, 1);
        chk("lu_x0_idex_clr", idex_clr, 0);
        tick();
        chk("lu_x0_stall_cnt", stall_cycles, 1);
        // match on rs2, then same match with uses_rs2 low
        set_lu(5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
        #1;
        chk("lu_rs2_pc_we", pc_we, 0);
        id_uses_rs2 = 1'b0;
        #1;
        chk("lu_rs2_unused_pc_we", pc_we, 1);
        id_uses_rs2 = 1'b1;
        tick();
        idle();
        chk("lu_rs2_stall_cnt", stall_cycles, 2);
        clr_cnt();
        chk("clr_stall", stall_cycles, 0);

        // branch beats load-use
        set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        ex_branch_taken = 1'b1;
        #1;
        chk("br_lu_pc_we", pc_we, 1);
        chk("br_lu_ifid_clr", ifid_clr, 1);
        chk("br_lu_idex_clr", idex_clr, 1);
        tick();
        idle();
        chk("br_lu_flush", flush_count, 1);
        chk("br_lu_stall", stall_cycles, 1);
        clr_cnt();

        // memory freeze with a pending branch
        mem_busy = 1'b1;
        ex_branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("frz_we", {pc_we, ifid_we, idex_we, exmem_we}, 0);
            chk("frz_clr", {ifid_clr, idex_clr}, 0);
            tick();
        end
        chk("frz_flush", flush_count, 0);
        chk("frz_stall", stall_cycles, 4);
        mem_busy = 1'b0;
        #1;
        chk("frz_rel_pc_we", pc_we, 1);
        chk("frz_rel_ifid_clr", ifid_clr, 1);
        tick();
        idle();
        chk("frz_rel_flush", flush_count, 1);
        clr_cnt();

        // halt handshake, cycle 0 = request cycle
        halt_req = 1'b1;
        #1;
        chk("h_c0_pc_we", pc_we, 1);
        chk("h_c0_ack", halt_ack, 0);
        tick();
        chk("h_c1_pc_we", pc_we, 0);
        chk("h_c1_ifid_clr", ifid_clr, 1);
        chk("h_c1_ack", halt_ack, 0);
        tick();
        chk("h_c2_ack", halt_ack, 0);
        tick();
        chk("h_c3_ack", halt_ack, 0);
        tick();
        chk("h_c4_ack", halt_ack, 1);
        chk("h_c4_we", {pc_we, ifid_we, idex_we, exmem_we}, 0);
        tick();
        chk("h_c5_ack", halt_ack, 1);
        halt_req = 1'b0;
        #1;
        chk("h_drop_ack_held", halt_ack, 1);
        tick();
        chk("h_run_ack", halt_ack, 0);
        chk("h_run_pc_we", pc_we, 1);
        chk("h_stall", stall_cycles, 0);

        // taken branch on 2nd drain cycle reloads the drain counter
        halt_req = 1'b1;
        tick();
        tick();
        ex_branch_taken = 1'b1;
        #1;
        chk("dx_br_pc_we", pc_we, 1);
        chk("dx_br_ifid_clr", ifid_clr, 1);
        tick();
        ex_branch_taken = 1'b0;
        for (int c = 3; c <= 5; c++) begin
            #1;
            chk("dx_ack_low", halt_ack, 0);
            tick();
        end
        chk("dx_c6_ack", halt_ack, 1);
        chk("dx_flush", flush_count, 1);

        // back to RUN, enter DRAIN again, take a stall, then reset mid-drain
        halt_req = 1'b0;
        tick();
        halt_req = 1'b1;
        tick();
        mem_busy = 1'b1;
        tick();
        mem_busy = 1'b0;
        chk("rd_stall_pre", stall_cycles, 1);
        chk("rd_drain_pc_we", pc_we, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("rd_ack", halt_ack, 0);
        chk("rd_stall", stall_cycles, 0);
        chk("rd_flush", flush_count, 0);
        chk("rd_pc_we", pc_we, 1);
        halt_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // 4-bit counter wraps after 16 stalls
        mem_busy = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        mem_busy = 1'b0;
        chk("wrap_stall", stall_cycles, 1);
        ex_branch_taken = 1'b1;
        tick();
        ex_branch_taken = 1'b0;
        chk("wrap_flush_pre", flush_count, 1);
        cnt_clr = 1'b1;
        mem_busy = 1'b1;
        tick();
        mem_busy = 1'b0;
        ex_branch_taken = 1'b1;
        tick();
        idle();
        chk("clr_pri_stall", stall_cycles, 0);
        chk("clr_pri_flush", flush_count, 0);
        tick();
        chk("clr_idle_stall", stall_cycles, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
